// File: rtl/acc_result_tx_pkg.sv
// Shared definitions for the accumulator result UART transmitter: FSM states,
// line levels and default timing.
package acc_result_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } tx_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

  localparam int DEF_DATA_W       = 16;
  localparam int DEF_CLKS_PER_BIT = 5208;

  // Index width for a counter over n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_result_tx_if.sv
// Control-unit / accumulator side bus of the result transmitter plus the TX pin.
// The master drives the request and data; the slave (transmitter) drives line and status.
interface acc_result_tx_if
  import acc_result_tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [DATA_W-1:0] Entrada;
  logic              Inicio;
  logic              Tx;
  logic              Ocupado;
  logic              Listo;

  modport master (
    output Entrada,
    output Inicio,
    input  Tx,
    input  Ocupado,
    input  Listo
  );

  modport slave (
    input  Entrada,
    input  Inicio,
    output Tx,
    output Ocupado,
    output Listo
  );

endinterface

// File: rtl/acc_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// bit_end is high during the final cycle of a bit; clr forces the count back to 0.
module acc_baud_gen
  import acc_result_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_end
);

  localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    bit_end = (cnt_q == CNT_MAX);
    cnt_d   = cnt_q + CNT_W'(1);
    if (clr || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acc_result_tx.sv
// Snapshots the accumulator on Inicio and sends it as 8N1 UART bytes, MSB byte first.
// Acceptance to Listo takes NBYTES*10*CLKS_PER_BIT cycles; Inicio is ignored while busy.
module acc_result_tx
  import acc_result_tx_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic           clk,
  input  logic           reset,
  acc_result_tx_if.slave bus
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BYTE_W = idx_w(NBYTES);

  tx_state_t         state_q,    state_d;
  logic [2:0]        bit_idx_q,  bit_idx_d;
  logic [BYTE_W-1:0] byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0] shadow_q,   shadow_d;
  logic              tx_q,       tx_d;
  logic              ocupado_q,  ocupado_d;
  logic              listo_q,    listo_d;

  logic       bit_end;
  logic       baud_clr;
  logic [7:0] cur_byte;

  acc_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clr     (baud_clr),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shadow_d   = shadow_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.Inicio) begin
          state_d    = ST_START;
          shadow_d   = bus.Entrada;
          byte_idx_d = BYTE_W'(NBYTES - 1);
          bit_idx_d  = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        // Bytes go out from the top of the shadow register downwards.
        if (bit_end) begin
          if (byte_idx_q != '0) begin
            state_d    = ST_START;
            byte_idx_d = byte_idx_q - BYTE_W'(1);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cur_byte = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (byte_idx_d == BYTE_W'(b)) begin
        cur_byte = shadow_d[b*8 +: 8];
      end
    end

    // Outputs are derived from the next state so they change on the entry edge.
    case (state_d)
      ST_START: tx_d = UART_START_LVL;
      ST_DATA:  tx_d = cur_byte[bit_idx_d];
      ST_STOP:  tx_d = UART_STOP_LVL;
      default:  tx_d = UART_IDLE_LVL;
    endcase
    ocupado_d = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);
    listo_d   = (state_d == ST_DONE);

    baud_clr = (state_d != state_q) || (state_q == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shadow_q   <= '0;
      tx_q       <= UART_IDLE_LVL;
      ocupado_q  <= 1'b0;
      listo_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shadow_q   <= shadow_d;
      tx_q       <= tx_d;
      ocupado_q  <= ocupado_d;
      listo_q    <= listo_d;
    end
  end

  assign bus.Tx      = tx_q;
  assign bus.Ocupado = ocupado_q;
  assign bus.Listo   = listo_q;

endmodule

// File: tb/tb_acc_result_tx.sv
// Bench for acc_result_tx at CLKS_PER_BIT=4: UART decode of a vector table, a per-cycle
// waveform model for random and corner-case frames, reset and back-to-back handling.
module tb_acc_result_tx;

  localparam int C      = 4;
  localparam int FRAME  = 20 * C;     // two bytes of ten bits
  localparam int PERIOD = FRAME + 2;  // frame, DONE cycle, one IDLE cycle

  logic clk;
  logic reset;

  acc_result_tx_if #(.DATA_W(16)) bus ();

  acc_result_tx #(
    .DATA_W       (16),
    .CLKS_PER_BIT (C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic tx_tr [0:511];
  logic oc_tr [0:511];
  logic li_tr [0:511];

  typedef struct {
    logic [15:0] entrada;
    logic [7:0]  exp_first;
    logic [7:0]  exp_second;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected {Tx, Ocupado, Listo} cycle cyc after acceptance of value v.
  function automatic logic [2:0] model(input logic [15:0] v, input int cyc);
    int         bp;
    int         slot;
    logic [7:0] by;
    if (cyc >= FRAME) return (cyc == FRAME) ? 3'b101 : 3'b100;
    bp   = cyc / C;
    slot = bp % 10;
    by   = (bp < 10) ? v[15:8] : v[7:0];
    if (slot == 0) return 3'b010;
    if (slot == 9) return 3'b110;
    return {by[slot-1], 2'b10};
  endfunction

  task automatic start_frame(input logic [15:0] v, input bit hold);
    @(posedge clk);
    #1;
    bus.Entrada = v;
    bus.Inicio  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.Inicio = 1'b0;
  endtask

  task automatic record(input int ncyc, input int poke_cyc, input logic [15:0] poke_val,
                        input int rel_cyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      tx_tr[i] = bus.Tx;
      oc_tr[i] = bus.Ocupado;
      li_tr[i] = bus.Listo;
      if (i == poke_cyc) begin
        bus.Entrada = poke_val;
        bus.Inicio  = 1'b1;
      end
      if (i == rel_cyc) bus.Inicio = 1'b0;
    end
  endtask

  task automatic frame_check(input logic [15:0] v, input int ncyc, input string tag);
    for (int i = 0; i < ncyc; i++) begin
      check($sformatf("%s cyc%0d", tag, i), {29'd0, tx_tr[i], oc_tr[i], li_tr[i]},
            {29'd0, model(v, i % PERIOD)});
    end
  endtask

  task automatic idle_check(input int ncyc, input string tag);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check($sformatf("%s cyc%0d", tag, i), {29'd0, bus.Tx, bus.Ocupado, bus.Listo}, 32'd4);
    end
  endtask

  // Mid-bit UART decode of a recorded frame, independent of the waveform model.
  task automatic decode_check(input int idx);
    logic [7:0] got [2];
    int         oc_cnt;
    int         li_cnt;
    for (int k = 0; k < 2; k++) begin
      int base;
      base = k * 10 * C + C / 2;
      check($sformatf("v%0d b%0d start", idx, k), {31'd0, tx_tr[base]}, 32'd0);
      for (int b = 0; b < 8; b++) got[k][b] = tx_tr[base + (b + 1) * C];
      check($sformatf("v%0d b%0d stop", idx, k), {31'd0, tx_tr[base + 9 * C]}, 32'd1);
    end
    check($sformatf("v%0d first byte", idx), {24'd0, got[0]}, {24'd0, vecs[idx].exp_first});
    check($sformatf("v%0d second byte", idx), {24'd0, got[1]}, {24'd0, vecs[idx].exp_second});
    oc_cnt = 0;
    li_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (oc_tr[i]) oc_cnt++;
      if (li_tr[i]) li_cnt++;
    end
    check($sformatf("v%0d ocupado width", idx), oc_cnt, FRAME);
    check($sformatf("v%0d listo count", idx), li_cnt, 1);
    check($sformatf("v%0d listo at 80", idx), {31'd0, li_tr[FRAME]}, 32'd1);
  endtask

  initial begin
    int          li_cnt;
    int          hi_cnt;
    logic [15:0] rv;

    vecs[0] = '{16'hA53C, 8'hA5, 8'h3C};
    vecs[1] = '{16'h0000, 8'h00, 8'h00};
    vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF};
    vecs[3] = '{16'h0001, 8'h00, 8'h01};
    vecs[4] = '{16'h8001, 8'h80, 8'h01};

    reset       = 1'b1;
    bus.Entrada = '0;
    bus.Inicio  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    idle_check(20, "reset idle");

    for (int v = 0; v < 5; v++) begin
      start_frame(vecs[v].entrada, 1'b0);
      record(PERIOD, -1, 16'h0, -1);
      decode_check(v);
    end

    // Entrada change plus a second Inicio ten cycles into the frame.
    start_frame(16'hA53C, 1'b0);
    record(PERIOD, 9, 16'hFFFF, 10);
    frame_check(16'hA53C, PERIOD, "ignore inicio");
    idle_check(4, "after ignored");

    // Inicio held high: frames separated by DONE plus one IDLE cycle.
    start_frame(16'h0001, 1'b1);
    record(2 * PERIOD, -1, 16'h0, 2 * PERIOD - 1);
    frame_check(16'h0001, 2 * PERIOD, "back2back");
    idle_check(6, "after b2b");

    // Reset during the third data bit of the first byte.
    start_frame(16'h0000, 1'b0);
    record(13, -1, 16'h0, -1);
    reset = 1'b1;
    @(negedge clk);
    check("mid reset line", {29'd0, bus.Tx, bus.Ocupado, bus.Listo}, 32'd4);
    reset  = 1'b0;
    li_cnt = 0;
    hi_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.Listo) li_cnt++;
      if (bus.Tx && !bus.Ocupado) hi_cnt++;
    end
    check("no listo after reset", li_cnt, 0);
    check("idle after reset", hi_cnt, 100);
    start_frame(16'hC3A7, 1'b0);
    record(PERIOD, -1, 16'h0, -1);
    frame_check(16'hC3A7, PERIOD, "post reset");

    for (int r = 0; r < 8; r++) begin
      rv = 16'($urandom);
      start_frame(rv, 1'b0);
      record(PERIOD, -1, 16'h0, -1);
      frame_check(rv, PERIOD, $sformatf("rand%0d %04h", r, rv));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
